burst_bus_arbiter: RTL
======================

Name: burst_bus_arbiter

Overview:
Shares one burst memory controller port between two requesters: the video framebuffer reader (requester 0, real-time, read-only) and a host/blitter port (requester 1, read and write). It sits between the requester-side burst buses and the memory controller. It sequences one burst at a time and steers read data back to the requester that issued the read. Video has fixed priority, bounded by an anti-starvation counter for the host.

Parameters:
BURST_BEATS, 4, 64-bit data beats per command, for both read and write.
ADDR_W, 21, word address width.
MAX_V_CONSEC, 8, maximum consecutive video grants while the host is waiting; range 1..255.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
v_cmd_en  in  1  video read request; held until accepted
v_addr  in  ADDR_W  video burst address
v_accept  out  1  one-cycle pulse when the video command is issued to memory
v_rd_data  out  64  read beat to video
v_rd_data_valid  out  1  read beat strobe to video
h_cmd_en  in  1  host request; held until accepted
h_cmd  in  1  0 = read, 1 = write
h_addr  in  ADDR_W  host burst address
h_wr_data  in  64  host write beat
h_data_mask  in  8  host byte mask; 1 = masked
h_wr_next  out  1  host must present the next write beat on the following cycle
h_accept  out  1  one-cycle pulse when the host command is issued to memory
h_rd_data  out  64  read beat to host
h_rd_data_valid  out  1  read beat strobe to host
mem_cmd_en  out  1  command strobe to memory
mem_cmd  out  1  0 = read, 1 = write
mem_addr  out  ADDR_W  command address
mem_wr_data  out  64  write beat
mem_data_mask  out  8  write byte mask
mem_cmd_ready  in  1  memory can accept a command this cycle
mem_rd_data  in  64  read beat
mem_rd_data_valid  in  1  read beat strobe

Behaviour:
- Reset: state IDLE; all *_accept, *_valid, h_wr_next, mem_cmd_en and counters are 0; mem_addr, mem_wr_data and mem_data_mask are 0; the owner register is video.
- States: IDLE, ISSUE, RD_WAIT, WR_BEATS.
- IDLE: picks a winner combinationally and registers it, then moves to ISSUE. No request keeps the block in IDLE.
- Arbitration: video wins unless the host is requesting and v_consec == MAX_V_CONSEC. A host grant clears v_consec. A video grant increments v_consec (saturating) only while h_cmd_en is high; otherwise it clears v_consec.
- ISSUE: mem_cmd_en = 1 with the registered command and address. The cycle mem_cmd_ready = 1 is acceptance. On acceptance:
  - the winner's *_accept pulses in the same cycle;
  - a read goes to RD_WAIT;
  - a write places beat 0 on mem_wr_data in the same cycle, asserts h_wr_next, and goes to WR_BEATS.
- Request withdrawal: if the winner's cmd_en drops while in ISSUE before acceptance, the block returns to IDLE with no issue and no accept pulse. The requester contract still forbids withdrawal.
- WR_BEATS: h_wr_data and h_data_mask are forwarded combinationally on each of the following BURST_BEATS-1 cycles. h_wr_next is high on all but the last beat. The block then returns to IDLE.
- RD_WAIT: each mem_rd_data_valid is steered to the owner's rd_data/valid with zero latency; the other requester's valid stays 0. The block counts BURST_BEATS beats and then returns to IDLE.
- Outstanding commands: exactly one command is outstanding at a time; a new command is never issued before the read data completes.
- Stray data: mem_rd_data_valid outside RD_WAIT is dropped and never forwarded.
- Minimum turnaround: IDLE to ISSUE costs 1 cycle, so back-to-back reads are spaced BURST_BEATS+2 cycles at minimum.
- Simultaneous requests with v_consec below the limit: video wins, and the host waits at most MAX_V_CONSEC video bursts.
- Asynchronous reset mid-burst: aborts immediately. Remaining beats arriving after reset is released are dropped as stray.

Optional Feature:
BURST_ARBITER_STATS_EN
- Defined: adds a 16-bit saturating host_wait_max output, the longest number of cycles h_cmd_en was held before h_accept. It also adds a 16-bit v_grant_count output that wraps on overflow. Both clear on reset.
- Undefined: neither output exists and no counter logic is built.

Decomposition:
- Shared package burst_arb_pkg: state enum arb_state_e; requester enum arb_req_e (REQ_VIDEO, REQ_HOST); localparams CMD_READ = 0 and CMD_WRITE = 1.
- One sub-module, burst_beat_counter: counts beats up to BURST_BEATS and pulses done. It is instantiated once for RD_WAIT and reused for WR_BEATS.

Test Plan:
- Video-only read: v_cmd_en with v_addr = 0x100 and mem_cmd_ready = 1 → mem_cmd_en with addr 0x100 and a v_accept pulse. Four returned beats appear on v_rd_data_valid; h_rd_data_valid stays 0.
- Contention, MAX_V_CONSEC = 2: both requesting continuously → grant order V, V, H, V, V, H, ...; host wait is at most 2 bursts.
- Host write with mask 0x0F: beats D0..D3 appear on consecutive cycles on mem_wr_data with mem_cmd = 1 on the D0 cycle. h_wr_next is high on exactly 3 cycles.
- mem_cmd_ready held low for 5 cycles: command and address stay stable, with no accept pulse until ready rises.
- Reset asserted after 2 of 4 read beats: outputs are 0 on the same cycle. Beats 3 and 4 arriving after release are not forwarded, and the next video request is served normally.
- Stray mem_rd_data_valid in IDLE → no valid pulse on either requester.

Source files
------------

// File: rtl/burst_arb_pkg.sv
// Shared types and constants for the burst bus arbiter.
package burst_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StWrBeats
    } arb_state_e;

    typedef enum logic {
        REQ_VIDEO = 1'b0,
        REQ_HOST  = 1'b1
    } arb_req_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter shared by the read and write phases; done pulses on the final beat.
module burst_beat_counter #(
    parameter int unsigned BURST_BEATS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    output logic done
);

    localparam int unsigned CW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CW-1:0] LastBeat = CW'(BURST_BEATS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count beats and wrap back to zero on the last one.
    always_comb begin
        done  = inc && (cnt_q == LastBeat);
        cnt_d = cnt_q;
        if (done) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Beat count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/burst_bus_arbiter.sv
// Two-requester burst arbiter: video (fixed priority, read-only) and host (read/write)
// share one memory command port, one burst outstanding at a time.
// Optional BURST_ARBITER_STATS_EN adds host_wait_max and v_grant_count outputs.
module burst_bus_arbiter
    import burst_arb_pkg::*;
#(
    parameter int unsigned BURST_BEATS  = 4,
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned MAX_V_CONSEC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_cmd_en,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_accept,
    output logic [63:0]       v_rd_data,
    output logic              v_rd_data_valid,
    input  logic              h_cmd_en,
    input  logic              h_cmd,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [63:0]       h_wr_data,
    input  logic [7:0]        h_data_mask,
    output logic              h_wr_next,
    output logic              h_accept,
    output logic [63:0]       h_rd_data,
    output logic              h_rd_data_valid,
    output logic              mem_cmd_en,
    output logic              mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wr_data,
    output logic [7:0]        mem_data_mask,
    input  logic              mem_cmd_ready,
    input  logic [63:0]       mem_rd_data,
    input  logic              mem_rd_data_valid
`ifdef BURST_ARBITER_STATS_EN
    ,
    output logic [15:0]       host_wait_max,
    output logic [15:0]       v_grant_count
`endif
);

    localparam logic [7:0] MaxConsec = 8'(MAX_V_CONSEC);

    arb_state_e        state_q, state_d;
    arb_req_e          owner_q, owner_d;
    logic              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        v_consec_q, v_consec_d;
    logic              win_en;
    logic              beat_inc;
    logic              beat_done;

    // The registered winner must still be requesting for its command to go out.
    assign win_en = (owner_q == REQ_VIDEO) ? v_cmd_en : h_cmd_en;

    // Write beat 0 is counted on the accept cycle so WR_BEATS covers the remainder.
    assign beat_inc = ((state_q == StIssue) && win_en && mem_cmd_ready && (cmd_q == CMD_WRITE))
                    || (state_q == StWrBeats)
                    || ((state_q == StRdWait) && mem_rd_data_valid);

    burst_beat_counter #(
        .BURST_BEATS (BURST_BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (beat_inc),
        .done  (beat_done)
    );

    // Arbitration, command issue, write forwarding and read steering.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        cmd_d           = cmd_q;
        addr_d          = addr_q;
        v_consec_d      = v_consec_q;
        v_accept        = 1'b0;
        h_accept        = 1'b0;
        h_wr_next       = 1'b0;
        v_rd_data       = '0;
        v_rd_data_valid = 1'b0;
        h_rd_data       = '0;
        h_rd_data_valid = 1'b0;
        mem_cmd_en      = 1'b0;
        mem_cmd         = CMD_READ;
        mem_addr        = '0;
        mem_wr_data     = '0;
        mem_data_mask   = '0;

        unique case (state_q)
            StIdle: begin
                if (h_cmd_en && (!v_cmd_en || (v_consec_q >= MaxConsec))) begin
                    owner_d    = REQ_HOST;
                    cmd_d      = h_cmd;
                    addr_d     = h_addr;
                    v_consec_d = '0;
                    state_d    = StIssue;
                end else if (v_cmd_en) begin
                    owner_d = REQ_VIDEO;
                    cmd_d   = CMD_READ;
                    addr_d  = v_addr;
                    // Only a waiting host makes video streaks count.
                    if (h_cmd_en) begin
                        v_consec_d = (v_consec_q < MaxConsec) ? v_consec_q + 8'd1 : v_consec_q;
                    end else begin
                        v_consec_d = '0;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!win_en) begin
                    state_d = StIdle;
                end else begin
                    mem_cmd_en = 1'b1;
                    mem_cmd    = cmd_q;
                    mem_addr   = addr_q;
                    if (mem_cmd_ready) begin
                        v_accept = (owner_q == REQ_VIDEO);
                        h_accept = (owner_q == REQ_HOST);
                        if (cmd_q == CMD_WRITE) begin
                            mem_wr_data   = h_wr_data;
                            mem_data_mask = h_data_mask;
                            h_wr_next     = !beat_done;
                            state_d       = beat_done ? StIdle : StWrBeats;
                        end else begin
                            state_d = StRdWait;
                        end
                    end
                end
            end
            StWrBeats: begin
                mem_wr_data   = h_wr_data;
                mem_data_mask = h_data_mask;
                h_wr_next     = !beat_done;
                if (beat_done) begin
                    state_d = StIdle;
                end
            end
            StRdWait: begin
                if (owner_q == REQ_VIDEO) begin
                    v_rd_data       = mem_rd_data;
                    v_rd_data_valid = mem_rd_data_valid;
                end else begin
                    h_rd_data       = mem_rd_data;
                    h_rd_data_valid = mem_rd_data_valid;
                end
                if (beat_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, owner and registered command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            owner_q    <= REQ_VIDEO;
            cmd_q      <= CMD_READ;
            addr_q     <= '0;
            v_consec_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            v_consec_q <= v_consec_d;
        end
    end

`ifdef BURST_ARBITER_STATS_EN
    logic [15:0] wait_cur_q, host_wait_max_q, v_grant_count_q;

    // Host wait tracking (cycles held before accept) and video grant count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cur_q      <= '0;
            host_wait_max_q <= '0;
            v_grant_count_q <= '0;
        end else begin
            if (h_accept) begin
                if (wait_cur_q > host_wait_max_q) begin
                    host_wait_max_q <= wait_cur_q;
                end
                wait_cur_q <= '0;
            end else if (h_cmd_en && (wait_cur_q != 16'hFFFF)) begin
                wait_cur_q <= wait_cur_q + 16'd1;
            end
            if (v_accept) begin
                v_grant_count_q <= v_grant_count_q + 16'd1;
            end
        end
    end

    assign host_wait_max = host_wait_max_q;
    assign v_grant_count = v_grant_count_q;
`endif

endmodule
